// File: rtl/calc_pkg.sv
// Shared definitions for the pipelined calculator.
//   CALC_DATA_W / CALC_ADDR_W : default operand width and register address width
//   calc_op_e                 : 4-bit opcode encoding driven on ctrl
// Opcodes 13..15 are unassigned and produce a zero result with carry 0.
package calc_pkg;

  localparam int CALC_DATA_W = 8;
  localparam int CALC_ADDR_W = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_NOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10,
    OP_LT  = 4'd11,
    OP_EQ  = 4'd12
  } calc_op_e;

endpackage

// File: rtl/calc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
//   clk, rst_n     : clock, asynchronous active-low reset (clears every entry)
//   ra_x, ra_y     : read addresses, rd_x / rd_y combinational read data
//   we, wa, wd     : write enable, write address, write data
// Entry 0 always reads as zero; writes addressed to it are dropped.
module calc_regfile
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int ADDR_W = CALC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_x,
  input  logic [ADDR_W-1:0] ra_y,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_y,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd_x = (ra_x == '0) ? '0 : regs[ra_x];
  assign rd_y = (ra_y == '0) ? '0 : regs[ra_y];

endmodule

// File: rtl/pipelined_calculator.sv
// Two-stage calculator: S1 reads operands and evaluates the ALU on accept,
// S2 holds the registered result and writes it back to the register file
// when the consumer takes it.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid / in_ready         : request handshake
//   wen, rw, rx, ry             : writeback enable, write/read-X/read-Y addresses
//   data_in, sel, ctrl          : external operand, X-source select, opcode
//   out_valid / out_ready       : result handshake
//   out_data, carry             : registered result and carry/borrow
// Build option: define CALC_FORWARD_EN to forward the pending S2 result into
// the operands instead of stalling on a read-after-write hazard.
module pipelined_calculator
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int ADDR_W = CALC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wen,
  input  logic [ADDR_W-1:0] rw,
  input  logic [ADDR_W-1:0] rx,
  input  logic [ADDR_W-1:0] ry,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sel,
  input  logic [3:0]        ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              carry
);

  logic              s2_wen;
  logic [ADDR_W-1:0] s2_rw;
  logic [DATA_W-1:0] rd_x, rd_y;
  logic [DATA_W-1:0] x_op, y_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [DATA_W:0]   sum_ext, diff_ext;
  logic              s2_live, hazard_x, hazard_y, hazard_stall;
  logic              accept, retire, wb_en;

  assign accept = in_valid && in_ready;
  assign retire = out_valid && out_ready;
  assign wb_en  = retire && s2_wen && (s2_rw != '0);

  calc_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra_x  (rx),
    .ra_y  (ry),
    .rd_x  (rd_x),
    .rd_y  (rd_y),
    .we    (wb_en),
    .wa    (s2_rw),
    .wd    (out_data)
  );

  // A pending S2 result only matters if it will actually land in a real register.
  assign s2_live  = out_valid && s2_wen && (s2_rw != '0);
  assign hazard_x = s2_live && sel && (s2_rw == rx);
  assign hazard_y = s2_live && (s2_rw == ry);

`ifdef CALC_FORWARD_EN
  // Any accept while S2 is occupied coincides with its retire, so the
  // forwarded value is exactly what the register will hold afterwards.
  assign x_op         = sel ? (hazard_x ? out_data : rd_x) : data_in;
  assign y_op         = hazard_y ? out_data : rd_y;
  assign hazard_stall = 1'b0;
`else
  assign x_op         = sel ? rd_x : data_in;
  assign y_op         = rd_y;
  assign hazard_stall = hazard_x || hazard_y;
`endif

  // Gated by rst_n so no request is offered to a design held in reset.
  assign in_ready = rst_n && (!out_valid || out_ready) && !hazard_stall;

  assign sum_ext  = {1'b0, x_op} + {1'b0, y_op};
  assign diff_ext = {1'b0, x_op} - {1'b0, y_op};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (ctrl)
      OP_ADD: {alu_c, alu_res} = sum_ext;
      OP_SUB: {alu_c, alu_res} = diff_ext;
      OP_AND: alu_res = x_op & y_op;
      OP_OR:  alu_res = x_op | y_op;
      OP_XOR: alu_res = x_op ^ y_op;
      OP_NOT: alu_res = ~x_op;
      OP_NOR: alu_res = ~(x_op | y_op);
      OP_SHL: begin
        alu_res = {x_op[DATA_W-2:0], 1'b0};
        alu_c   = x_op[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, x_op[DATA_W-1:1]};
        alu_c   = x_op[0];
      end
      OP_ROL: alu_res = {x_op[DATA_W-2:0], x_op[DATA_W-1]};
      OP_ROR: alu_res = {x_op[0], x_op[DATA_W-1:1]};
      OP_LT:  alu_res = {{(DATA_W-1){1'b0}}, (x_op < y_op)};
      OP_EQ:  alu_res = {{(DATA_W-1){1'b0}}, (x_op == y_op)};
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      carry     <= 1'b0;
      s2_wen    <= 1'b0;
      s2_rw     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= alu_res;
      carry     <= alu_c;
      s2_wen    <= wen;
      s2_rw     <= rw;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_calculator.sv
// Directed bench for pipelined_calculator (DATA_W=8, ADDR_W=3).
module tb_pipelined_calculator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       wen;
  logic [2:0] rw, rx, ry;
  logic [7:0] data_in;
  logic       sel;
  logic [3:0] ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       carry;

  int checks   = 0;
  int failures = 0;
  int stalls;

  typedef struct {
    logic [7:0] d;
    logic [3:0] op;
    logic [7:0] res;
    logic       c;
  } vec_t;

  // X from data_in, Y = r2 = 0x05
  vec_t vecs [16] = '{
    '{8'hFE, 4'd0,  8'h03, 1'b1},
    '{8'h03, 4'd1,  8'hFE, 1'b1},
    '{8'h0F, 4'd2,  8'h05, 1'b0},
    '{8'hA0, 4'd3,  8'hA5, 1'b0},
    '{8'h0F, 4'd4,  8'h0A, 1'b0},
    '{8'h0F, 4'd5,  8'hF0, 1'b0},
    '{8'hA0, 4'd6,  8'h5A, 1'b0},
    '{8'h81, 4'd7,  8'h02, 1'b1},
    '{8'h81, 4'd8,  8'h40, 1'b1},
    '{8'h81, 4'd9,  8'h03, 1'b0},
    '{8'h81, 4'd10, 8'hC0, 1'b0},
    '{8'h04, 4'd11, 8'h01, 1'b0},
    '{8'h05, 4'd11, 8'h00, 1'b0},
    '{8'h05, 4'd12, 8'h01, 1'b0},
    '{8'hFF, 4'd13, 8'h00, 1'b0},
    '{8'hFF, 4'd15, 8'h00, 1'b0}
  };

  pipelined_calculator #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wen       (wen),
    .rw        (rw),
    .rx        (rx),
    .ry        (ry),
    .data_in   (data_in),
    .sel       (sel),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for in_ready, take the accepting edge.
  task automatic issue(input logic s, input logic [2:0] x, input logic [2:0] y,
                       input logic [2:0] w, input logic we, input logic [7:0] d,
                       input logic [3:0] op, output int n_stall);
    sel = s; rx = x; ry = y; rw = w; wen = we; data_in = d; ctrl = op;
    in_valid = 1'b1;
    n_stall = 0;
    #1;
    while (!in_ready && n_stall < 8) begin
      @(posedge clk); #1;
      n_stall++;
    end
    check("accept_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wen = 1'b0; rw = '0; rx = '0; ry = '0;
    data_in = '0; sel = 1'b0; ctrl = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'h0);
    check("rst_carry", {31'b0, carry}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // r1 = 0xF0 + r0
    issue(1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 8'hF0, 4'd0, stalls);
    check("add_din_valid", {31'b0, out_valid}, 32'd1);
    check("add_din_data", {24'b0, out_data}, 32'hF0);
    check("add_din_carry", {31'b0, carry}, 32'd0);
    // r1 + r1, dependent on the write just issued
    issue(1'b1, 3'd1, 3'd1, 3'd0, 1'b0, 8'h00, 4'd0, stalls);
`ifdef CALC_FORWARD_EN
    check("dep_r1_stalls", stalls, 32'd0);
`else
    check("dep_r1_stalls", stalls, 32'd1);
`endif
    check("add_r1r1_data", {24'b0, out_data}, 32'hE0);
    check("add_r1r1_carry", {31'b0, carry}, 32'd1);

    // r2 = 0x05, then immediately r2 + 0x03
    issue(1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 8'h05, 4'd0, stalls);
    check("wr_r2_data", {24'b0, out_data}, 32'h05);
    issue(1'b0, 3'd0, 3'd2, 3'd0, 1'b0, 8'h03, 4'd0, stalls);
`ifdef CALC_FORWARD_EN
    check("dep_r2_stalls", stalls, 32'd0);
`else
    check("dep_r2_stalls", stalls, 32'd1);
`endif
    check("dep_r2_data", {24'b0, out_data}, 32'h08);
    check("dep_r2_carry", {31'b0, carry}, 32'd0);

    // Backpressure: r3 = 0x11 held in S2 for three cycles
    issue(1'b0, 3'd0, 3'd0, 3'd3, 1'b1, 8'h11, 4'd0, stalls);
    out_ready = 1'b0;
    sel = 1'b0; rx = '0; ry = '0; rw = '0; wen = 1'b0; data_in = 8'h01; ctrl = 4'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_out_data", {24'b0, out_data}, 32'h11);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_no_wb", {24'b0, dut.u_regfile.regs[3]}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_same_edge_data", {24'b0, out_data}, 32'h01);
    check("bp_same_edge_valid", {31'b0, out_valid}, 32'd1);
    check("bp_wb_r3", {24'b0, dut.u_regfile.regs[3]}, 32'h11);
    issue(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 8'h00, 4'd0, stalls);
    check("read_r3", {24'b0, out_data}, 32'h11);

    // Subtract with borrow, written to r0
    issue(1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 8'h02, 4'd1, stalls);
    check("sub_data", {24'b0, out_data}, 32'hFD);
    check("sub_carry", {31'b0, carry}, 32'd1);
    issue(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 4'd3, stalls);
    check("r0_no_stall", stalls, 32'd0);
    check("r0_reads_zero", {24'b0, out_data}, 32'h00);

    // Opcode table
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 3'd0, 3'd2, 3'd0, 1'b0, vecs[i].d, vecs[i].op, stalls);
      check($sformatf("op%0d_data", vecs[i].op), {24'b0, out_data}, {24'b0, vecs[i].res});
      check($sformatf("op%0d_carry", vecs[i].op), {31'b0, carry}, {31'b0, vecs[i].c});
    end

    // Reset with a pending write in S2
    issue(1'b0, 3'd0, 3'd0, 3'd4, 1'b1, 8'h77, 4'd0, stalls);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("pend_out_valid", {31'b0, out_valid}, 32'd1);
    check("pend_out_data", {24'b0, out_data}, 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_data", {24'b0, out_data}, 32'h0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_r1_cleared", {24'b0, dut.u_regfile.regs[1]}, 32'h0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("midrst_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("midrst_r4_zero", {24'b0, dut.u_regfile.regs[4]}, 32'h0);
    issue(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 8'h00, 4'd0, stalls);
    check("midrst_read_r4", {24'b0, out_data}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
